crypto_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares one crypto datapath

---
 rtl/crypto_rr_arbiter_if.sv | 29 ++
 rtl/crypto_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_crypto_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crypto_rr_arbiter_if.sv
// Bus bundle for crypto_rr_arbiter: per-queue write ports in, one packet stream out.
// master = upstream/downstream environment, slave = the arbiter.
interface crypto_rr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned SRC_WIDTH  = $clog2(NUM_QUEUES)
);
    logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_QUEUES-1:0]            in_wr;
    logic [NUM_QUEUES-1:0]            in_rdy;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic [SRC_WIDTH-1:0]             out_src;
    logic                             busy;

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr, out_src, busy
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr, out_src, busy
    );
endinterface

// File: rtl/crypto_rr_arbiter.sv
// Packet-granular round-robin arbiter: per-queue fall-through FIFOs, whole packets
// forwarded one at a time with the source queue index on out_src.
module crypto_rr_arbiter #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned NUM_QUEUES      = 4,
    parameter int unsigned SRC_WIDTH       = $clog2(NUM_QUEUES),
    parameter int unsigned FIFO_DEPTH_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    crypto_rr_arbiter_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int unsigned CNT_W = FIFO_DEPTH_BITS + 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                     state;
    logic [SRC_WIDTH-1:0]       grant;
    logic [SRC_WIDTH-1:0]       last_grant;
    logic [SRC_WIDTH-1:0]       next_grant;
    logic [SRC_WIDTH-1:0]       scan_q;
    logic                       found;

    logic [DATA_WIDTH-1:0]      mem_data [NUM_QUEUES][DEPTH];
    logic [CTRL_WIDTH-1:0]      mem_ctrl [NUM_QUEUES][DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr   [NUM_QUEUES];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr   [NUM_QUEUES];
    logic [CNT_W-1:0]           count    [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]      empty;
    logic [NUM_QUEUES-1:0]      full;
    logic [NUM_QUEUES-1:0]      rdy;
    logic [NUM_QUEUES-1:0]      push_q;
    logic [NUM_QUEUES-1:0]      pop_q;

    logic [DATA_WIDTH-1:0]      head_data;
    logic [CTRL_WIDTH-1:0]      head_ctrl;
    logic                       pop;

    logic [DATA_WIDTH-1:0]      out_data_r;
    logic [CTRL_WIDTH-1:0]      out_ctrl_r;
    logic [SRC_WIDTH-1:0]       out_src_r;
    logic                       out_wr_r;
    logic                       busy_r;

    assign head_data = mem_data[grant][rd_ptr[grant]];
    assign head_ctrl = mem_ctrl[grant][rd_ptr[grant]];
    assign pop       = (state != IDLE) && !empty[grant] && bus.out_rdy;

    // A write alongside a pop is accepted even when the FIFO is full.
    always_comb begin
        pop_q = '0;
        if (pop) pop_q[grant] = 1'b1;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            empty[q]  = (count[q] == '0);
            full[q]   = (count[q] == CNT_W'(DEPTH));
            rdy[q]    = (count[q] < CNT_W'(DEPTH - 1));
            push_q[q] = bus.in_wr[q] && (!full[q] || pop_q[q]);
        end
    end

    // Scan last_grant+1 .. last_grant+NUM_QUEUES, first non-empty queue wins.
    always_comb begin
        found      = 1'b0;
        next_grant = last_grant;
        scan_q     = '0;
        for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
            scan_q = SRC_WIDTH'((32'(last_grant) + i) % NUM_QUEUES);
            if (!found && !empty[scan_q]) begin
                found      = 1'b1;
                next_grant = scan_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            if (push_q[q]) begin
                mem_data[q][wr_ptr[q]] <= bus.in_data[q*DATA_WIDTH +: DATA_WIDTH];
                mem_ctrl[q][wr_ptr[q]] <= bus.in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                rd_ptr[q] <= '0;
                wr_ptr[q] <= '0;
                count[q]  <= '0;
            end
        end else begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                if (push_q[q]) wr_ptr[q] <= wr_ptr[q] + 1'b1;
                if (pop_q[q])  rd_ptr[q] <= rd_ptr[q] + 1'b1;
                count[q] <= count[q] + CNT_W'(push_q[q]) - CNT_W'(pop_q[q]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SRC_WIDTH'(NUM_QUEUES - 1);
            out_wr_r   <= 1'b0;
            out_data_r <= '0;
            out_ctrl_r <= '0;
            out_src_r  <= '0;
            busy_r     <= 1'b0;
        end else begin
            out_wr_r <= pop;
            if (pop) begin
                out_data_r <= head_data;
                out_ctrl_r <= head_ctrl;
                out_src_r  <= grant;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        busy_r     <= 1'b1;
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (pop && head_ctrl == '0) state <= DATA;
                end
                DATA: begin
                    if (pop && head_ctrl != '0) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy   = rdy;
    assign bus.out_wr   = out_wr_r;
    assign bus.out_data = out_data_r;
    assign bus.out_ctrl = out_ctrl_r;
    assign bus.out_src  = out_src_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_crypto_rr_arbiter.sv
// Directed bench for crypto_rr_arbiter: packet tables with expected source, words,
// busy and inter-word spacing, plus hand-written stall, backpressure and reset sequences.
`timescale 1ns/1ps
module tb_crypto_rr_arbiter;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 8;
    localparam int unsigned NQ = 4;
    localparam int unsigned SW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    crypto_rr_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .SRC_WIDTH(SW)) bus ();

    crypto_rr_arbiter #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .SRC_WIDTH(SW), .FIFO_DEPTH_BITS(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Input word plus what must come out for it: src=q, same ctrl/data, busy and
    // spacing (in cycles) from the previous output word; exp_gap 0 = unchecked.
    typedef struct {
        logic [SW-1:0] q;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        int unsigned   exp_gap;
        logic          exp_busy;
    } vec_t;

    typedef struct {
        logic [SW-1:0] src;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        int unsigned   cyc;
        logic          busy;
    } cap_t;

    vec_t        tbl[$];
    cap_t        cap[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(negedge clk) begin
        cap_t c;
        cyc++;
        if (bus.out_wr) begin
            c.src  = bus.out_src;
            c.ctrl = bus.out_ctrl;
            c.data = bus.out_data;
            c.cyc  = cyc;
            c.busy = bus.busy;
            cap.push_back(c);
        end
    end

    // Writes are only ever issued while in_rdy is high, so a full FIFO is never written.
    always @(posedge clk) begin
        if (reset) begin
            assert ((bus.in_wr & ~bus.in_rdy) == '0)
            else begin
                failures++;
                $display("FAIL protocol_wr_not_rdy actual=%b required=0000", bus.in_wr & ~bus.in_rdy);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int unsigned q, input int unsigned ndata, input logic [7:0] eop,
                           input int unsigned tag, input int unsigned hdr_gap, input int unsigned body_gap);
        vec_t v;
        for (int unsigned i = 0; i < ndata + 2; i++) begin
            v.q        = SW'(q);
            v.ctrl     = (i == 0) ? 8'hFF : ((i == ndata + 1) ? eop : 8'h00);
            v.data     = {8'hA5, 8'(tag), 8'(q), 32'h0BAD_F00D, 8'(i)};
            v.exp_gap  = (i == 0) ? hdr_gap : body_gap;
            v.exp_busy = (i != ndata + 1);
            tbl.push_back(v);
        end
    endtask

    task automatic write_word(input vec_t v);
        int unsigned t = 0;
        while (!bus.in_rdy[v.q] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL in_rdy_wait q=%0d actual=0 required=1", v.q);
        end else begin
            bus.in_data[v.q*DW +: DW] = v.data;
            bus.in_ctrl[v.q*CW +: CW] = v.ctrl;
            bus.in_wr[v.q]            = 1'b1;
            @(posedge clk); #1;
            bus.in_wr[v.q]            = 1'b0;
        end
    endtask

    task automatic expect_tbl(input string tname);
        int unsigned t = 0;
        while (cap.size() < tbl.size() && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("%s_count", tname), 64'(cap.size()), 64'(tbl.size()));
        for (int i = 0; i < tbl.size() && i < cap.size(); i++) begin
            check($sformatf("%s_src[%0d]", tname, i), 64'(cap[i].src), 64'(tbl[i].q));
            check($sformatf("%s_ctrl[%0d]", tname, i), 64'(cap[i].ctrl), 64'(tbl[i].ctrl));
            check($sformatf("%s_data[%0d]", tname, i), cap[i].data, tbl[i].data);
            check($sformatf("%s_busy[%0d]", tname, i), 64'(cap[i].busy), 64'(tbl[i].exp_busy));
            if (i > 0 && tbl[i].exp_gap != 0)
                check($sformatf("%s_gap[%0d]", tname, i), 64'(cap[i].cyc - cap[i-1].cyc), 64'(tbl[i].exp_gap));
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.in_wr   = '0;
        bus.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        cap.delete();
        tbl.delete();
    endtask

    task automatic wait_cap(input int unsigned n, input string name);
        int unsigned t = 0;
        while (cap.size() < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 64'(cap.size() >= n), 64'd1);
    endtask

    initial begin
        int unsigned stall_cyc;
        int unsigned in_window;

        bus.in_data = '0;
        bus.in_ctrl = '0;
        bus.in_wr   = '0;
        bus.out_rdy = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_wr",   64'(bus.out_wr),   64'd0);
        check("rst_out_data", bus.out_data,      64'd0);
        check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("rst_out_src",  64'(bus.out_src),  64'd0);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_in_rdy",   64'(bus.in_rdy),   64'hF);
        do_reset();

        // 1: single queue-0 packet, 8 words back to back
        add_pkt(0, 6, 8'h80, 1, 0, 1);
        foreach (tbl[i]) write_word(tbl[i]);
        expect_tbl("t1");

        // 2: all queues loaded under backpressure, served 0,1,2,3 with 1-cycle gaps
        do_reset();
        bus.out_rdy = 1'b0;
        add_pkt(0, 1, 8'h0F, 2, 0, 1);
        add_pkt(1, 1, 8'h0F, 2, 2, 1);
        add_pkt(2, 1, 8'h0F, 2, 2, 1);
        add_pkt(3, 1, 8'h0F, 2, 2, 1);
        foreach (tbl[i]) write_word(tbl[i]);
        @(posedge clk); #1;
        check("t2_no_out_while_blocked", 64'(cap.size()), 64'd0);
        bus.out_rdy = 1'b1;
        expect_tbl("t2");

        // 3: queue 2 back-to-back packets, exactly one bubble between them
        cap.delete();
        tbl.delete();
        add_pkt(2, 1, 8'h0F, 3, 0, 1);
        add_pkt(2, 1, 8'h01, 4, 2, 1);
        foreach (tbl[i]) write_word(tbl[i]);
        expect_tbl("t3");

        // 4: out_rdy low for 5 cycles in DATA, sequence must resume intact
        cap.delete();
        tbl.delete();
        add_pkt(0, 6, 8'hC0, 5, 0, 0);
        stall_cyc = 0;
        fork
            foreach (tbl[i]) write_word(tbl[i]);
            begin
                wait_cap(3, "t4_reach_data");
                bus.out_rdy = 1'b0;
                stall_cyc   = cyc;
                repeat (5) @(posedge clk);
                #1;
                check("t4_busy_in_stall", 64'(bus.busy), 64'd1);
                bus.out_rdy = 1'b1;
            end
        join
        expect_tbl("t4");
        in_window = 0;
        foreach (cap[i]) if (cap[i].cyc >= stall_cyc + 2 && cap[i].cyc <= stall_cyc + 6) in_window++;
        check("t4_no_out_wr_in_stall", 64'(in_window), 64'd0);

        // 5: queue 1 stalls mid-packet while queue 3 fills; grant must not move
        do_reset();
        add_pkt(1, 1, 8'h80, 6, 0, 1);
        add_pkt(3, 1, 8'h0F, 7, 2, 1);
        tbl[2].exp_gap = 0;
        write_word(tbl[0]);
        write_word(tbl[1]);
        write_word(tbl[3]);
        write_word(tbl[4]);
        check("t5_in_rdy3_at_2", 64'(bus.in_rdy[3]), 64'd1);
        write_word(tbl[5]);
        check("t5_in_rdy3_at_3", 64'(bus.in_rdy[3]), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("t5_words_before_eop", 64'(cap.size()), 64'd2);
        check("t5_busy_while_starved", 64'(bus.busy), 64'd1);
        write_word(tbl[2]);
        expect_tbl("t5");

        // 6: async reset during queue-0 DATA, then queue 1 wins after release
        do_reset();
        add_pkt(0, 3, 8'h80, 8, 0, 1);
        for (int i = 0; i < 4; i++) write_word(tbl[i]);
        wait_cap(2, "t6_reach_data");
        reset = 1'b0;
        #1;
        check("t6_rst_out_wr",   64'(bus.out_wr),   64'd0);
        check("t6_rst_busy",     64'(bus.busy),     64'd0);
        check("t6_rst_out_data", bus.out_data,      64'd0);
        check("t6_rst_out_src",  64'(bus.out_src),  64'd0);
        check("t6_rst_in_rdy",   64'(bus.in_rdy),   64'hF);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        cap.delete();
        tbl.delete();
        add_pkt(1, 1, 8'h03, 9, 0, 1);
        foreach (tbl[i]) write_word(tbl[i]);
        expect_tbl("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
